// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative radix-2 multiply/divide unit with HI/LO result registers. It sits
// beside the ALU in EX. One product or quotient bit is resolved per cycle.
// The op runs IDLE -> CALC (WIDTH iterations) -> FIX. FIX applies the sign
// correction and writes HI/LO.
//
// Build option:
//   MULDIV_DIV_EN  defined   : MULT, MULTU, DIV and DIVU are all supported.
//   MULDIV_DIV_EN  undefined : the divider is not built, and DIV/DIVU starts
//                              are ignored. Multiply is unchanged.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   start    in   operation request, sampled only in IDLE
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    in   multiplicand / dividend
//   src_b    in   multiplier / divisor
//   flush    in   abort the in-flight op; in IDLE it suppresses start
//   wr_hi    in   MTHI write enable (IDLE only)
//   wr_lo    in   MTLO write enable (IDLE only)
//   wr_data  in   MTHI/MTLO data
//   busy     out  operation in flight (registered)
//   done     out  one-cycle pulse when HI/LO take a new result (registered)
//   hi, lo   out  result registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   aReg;     // |a|; also serves as the dividend shift register
  logic [WIDTH-1:0]   bReg;     // |b|; also serves as the multiplier shift register
  logic [2*WIDTH-1:0] acc;      // product, or {remainder, quotient}
  logic               negRes;   // negate the product or quotient in FIX

  logic               opSigned;
  logic               startOk;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     mulSum;

`ifdef MULDIV_DIV_EN
  logic               isDiv;
  logic               divZero;
  logic               zeroHold;  // gives a divide-by-zero its second busy cycle
  logic               negRem;    // remainder follows the dividend's sign
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
`endif

  // Unsigned W-bit magnitude, so the most negative value maps onto itself
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v,
                                            input logic doNeg);
    return doNeg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] v,
                                               input logic doNeg);
    return doNeg ? ({(2*WIDTH){1'b0}} - v) : v;
  endfunction

  always_comb begin
    opSigned = ~op[0];
    absA     = magnitude(src_a, opSigned);
    absB     = magnitude(src_b, opSigned);
`ifdef MULDIV_DIV_EN
    startOk  = start & ~flush;
`else
    startOk  = start & ~flush & ~op[1];
`endif
    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is 1. The sum is W+1 bits so the carry survives.
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bReg[0] ? {1'b0, aReg} : {(WIDTH+1){1'b0}});
`ifdef MULDIV_DIV_EN
    // Restoring step: bring in the next dividend bit and trial-subtract the
    // divisor. A negative result (MSB set) means the old remainder is kept.
    divShift = {acc[2*WIDTH-1:WIDTH], aReg[WIDTH-1]};
    divDiff  = divShift - {1'b0, bReg};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
`ifdef MULDIV_DIV_EN
      zeroHold <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // ---- IDLE: MTHI/MTLO writes and operand capture ----
        IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (startOk) begin
            aReg   <= absA;
            bReg   <= absB;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            negRes <= opSigned & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            isDiv    <= op[1];
            negRem   <= opSigned & src_a[WIDTH-1];
            divZero  <= op[1] & (src_b == '0);
            zeroHold <= 1'b0;
            state    <= (op[1] && (src_b == '0)) ? FIX : CALC;
`else
            state  <= CALC;
`endif
          end
        end

        // ---- CALC: one result bit per cycle ----
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
`ifdef MULDIV_DIV_EN
            if (isDiv) begin
              if (!divDiff[WIDTH])
                acc <= {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
              else
                acc <= {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
              aReg <= aReg << 1;
            end else begin
              acc  <= {mulSum, acc[WIDTH-1:1]};
              bReg <= bReg >> 1;
            end
`else
            acc  <= {mulSum, acc[WIDTH-1:1]};
            bReg <= bReg >> 1;
`endif
            count <= count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end

        // ---- FIX: sign correction and HI/LO write-back ----
        FIX: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
`ifdef MULDIV_DIV_EN
            if (divZero && !zeroHold) begin
              zeroHold <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (isDiv) begin
                // A divide by zero still reports done but leaves HI/LO unchanged
                if (!divZero) begin
                  lo <= negW(acc[WIDTH-1:0], negRes);
                  hi <= negW(acc[2*WIDTH-1:WIDTH], negRem);
                end
              end else begin
                {hi, lo} <= neg2W(acc, negRes);
              end
            end
`else
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            {hi, lo} <= neg2W(acc, negRes);
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request for one edge; returns just after the accepting edge k
  task automatic startOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat = edges after the current point until done (-1 if none within maxCyc);
  // bc counts busy samples, including the current one
  task automatic waitDone(input int maxCyc, output int lat, output int bc);
    lat = -1;
    bc  = busy ? 1 : 0;
    for (int i = 1; i <= maxCyc; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bc++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expHi,
                       input logic [W-1:0] expLo, input int expLat, output int bc);
    int lat;
    startOp(o, a, b);
    waitDone(100, lat, bc);
    checkVal({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkVal({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    checkVal({tag, "_hilo"}, {hi, lo}, {expHi, expLo});
  endtask

  initial begin
    int bc;
    int lat;
    rst = 1'b0; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_busy", 64'(busy), 64'd0);
    checkVal("reset_done", 64'(done), 64'd0);
    checkVal("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b1;

    // Multiplies, back to back
    runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, bc);
    checkVal("multu_max_busy_cycles", 64'(bc), 64'd33);
    runOp("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, bc);
    runOp("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, bc);
    runOp("mult_negneg", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33, bc);
    runOp("multu_shift", 2'b01, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 33, bc);

    // MTHI / MTLO
    wr_data = 32'h1234; wr_hi = 1'b1;
    @(posedge clk); #1; wr_hi = 1'b0;
    checkVal("mthi", {hi, lo}, {32'h1234, 32'h2345_6780});
    wr_data = 32'hABCD; wr_hi = 1'b1; wr_lo = 1'b1;
    @(posedge clk); #1; wr_hi = 1'b0; wr_lo = 1'b0;
    checkVal("mthi_mtlo", {hi, lo}, {32'hABCD, 32'hABCD});
    wr_data = 32'h1234; wr_hi = 1'b1;
    @(posedge clk); #1; wr_hi = 1'b0;
    checkVal("mthi_again", {hi, lo}, {32'h1234, 32'hABCD});

`ifdef MULDIV_DIV_EN
    runOp("divu_zero", 2'b11, 32'd9, 32'd0, 32'h1234, 32'hABCD, 2, bc);
    runOp("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, bc);
    runOp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, bc);
    runOp("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, bc);
    runOp("div_negdivisor", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, bc);
`else
    startOp(2'b11, 32'd9, 32'd3);
    checkVal("nodiv_busy", 64'(busy), 64'd0);
    waitDone(40, lat, bc);
    checkVal("nodiv_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    checkVal("nodiv_busy_cycles", 64'(bc), 64'd0);
    checkVal("nodiv_hilo", {hi, lo}, {32'h1234, 32'hABCD});
`endif

    // Known HI/LO for the abort tests
    wr_data = 32'h0F0F_0F0F; wr_hi = 1'b1; wr_lo = 1'b1;
    @(posedge clk); #1; wr_hi = 1'b0; wr_lo = 1'b0;

    // Flush mid-operation
    startOp(2'b01, 32'd5, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checkVal("flush_busy", 64'(busy), 64'd0);
    waitDone(40, lat, bc);
    checkVal("flush_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    checkVal("flush_hilo", {hi, lo}, {32'h0F0F_0F0F, 32'h0F0F_0F0F});

    // Flush in IDLE suppresses start
    op = 2'b01; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    checkVal("idle_flush_busy", 64'(busy), 64'd0);

    // Start while busy is ignored
    startOp(2'b01, 32'd7, 32'd6);
    repeat (5) begin @(posedge clk); #1; end
    op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    waitDone(100, lat, bc);
    checkVal("busy_start_latency", 64'(lat), 64'd27);
    checkVal("busy_start_hilo", {hi, lo}, {32'h0, 32'd42});

    // Write with start in the same cycle, then a write while busy
    wr_data = 32'hDEAD_BEEF; wr_hi = 1'b1; wr_lo = 1'b1;
    op = 2'b00; src_a = 32'hFFFF_FFFE; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    checkVal("wr_with_start", {hi, lo}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    wr_data = 32'h0; wr_hi = 1'b1;
    @(posedge clk); #1; wr_hi = 1'b0;
    checkVal("wr_while_busy", 64'(hi), 64'hDEAD_BEEF);
    waitDone(100, lat, bc);
    checkVal("wr_start_latency", 64'(lat), 64'd32);
    checkVal("wr_start_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    // Reset during a multiply
    startOp(2'b00, 32'hFFFF_FFFD, 32'd5);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    checkVal("midop_reset_hilo", {hi, lo}, 64'd0);
    checkVal("midop_reset_busy", 64'(busy), 64'd0);
    waitDone(40, lat, bc);
    checkVal("midop_reset_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

    runOp("after_reset", 2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 33, bc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
